// File: rtl/decode_execute_register.sv
// decode_execute_register: ID/EX pipeline register with writeback bypass at
// capture, writeback refresh while stalled, load-use bubble insertion, flush.
module decode_execute_register #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH   = 5,
    parameter int unsigned CONTROL_WIDTH = 16,
    parameter int unsigned LOAD_BIT      = 0
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     inValid,
    input  logic [DATA_WIDTH-1:0]    inPc,
    input  logic [INDEX_WIDTH-1:0]   inSource1Index,
    input  logic [INDEX_WIDTH-1:0]   inSource2Index,
    input  logic [DATA_WIDTH-1:0]    inSource1Data,
    input  logic [DATA_WIDTH-1:0]    inSource2Data,
    input  logic [DATA_WIDTH-1:0]    inImmediate,
    input  logic [INDEX_WIDTH-1:0]   inRdIndex,
    input  logic [CONTROL_WIDTH-1:0] inControl,
    input  logic                     wbShouldWrite,
    input  logic [INDEX_WIDTH-1:0]   wbWriteIndex,
    input  logic [DATA_WIDTH-1:0]    wbWriteData,
    output logic                     loadUseHazard,
    output logic                     outValid,
    output logic [DATA_WIDTH-1:0]    outPc,
    output logic [INDEX_WIDTH-1:0]   outSource1Index,
    output logic [INDEX_WIDTH-1:0]   outSource2Index,
    output logic [DATA_WIDTH-1:0]    outSource1Data,
    output logic [DATA_WIDTH-1:0]    outSource2Data,
    output logic [DATA_WIDTH-1:0]    outImmediate,
    output logic [INDEX_WIDTH-1:0]   outRdIndex,
    output logic [CONTROL_WIDTH-1:0] outControl
);

    logic                     valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
    logic [INDEX_WIDTH-1:0]   src1_idx_q,  src1_idx_d;
    logic [INDEX_WIDTH-1:0]   src2_idx_q,  src2_idx_d;
    logic [DATA_WIDTH-1:0]    src1_data_q, src1_data_d;
    logic [DATA_WIDTH-1:0]    src2_data_q, src2_data_d;
    logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
    logic [INDEX_WIDTH-1:0]   rd_idx_q,    rd_idx_d;
    logic [CONTROL_WIDTH-1:0] control_q,   control_d;

    logic                     load_use_c;
    logic                     wb_nonzero_c;
    logic [DATA_WIDTH-1:0]    cap_src1_c;
    logic [DATA_WIDTH-1:0]    cap_src2_c;

    // Load in EX whose destination is read by the valid instruction in decode.
    assign load_use_c = valid_q && control_q[LOAD_BIT] && (rd_idx_q != '0) && inValid &&
                        ((rd_idx_q == inSource1Index) || (rd_idx_q == inSource2Index));

    assign wb_nonzero_c = wbShouldWrite && (wbWriteIndex != '0);

    // Capture-time source operands: x0 reads zero, same-cycle writeback wins.
    always_comb begin
        cap_src1_c = inSource1Data;
        cap_src2_c = inSource2Data;
        if (inSource1Index == '0) begin
            cap_src1_c = '0;
        end else if (wbShouldWrite && (wbWriteIndex == inSource1Index)) begin
            cap_src1_c = wbWriteData;
        end
        if (inSource2Index == '0) begin
            cap_src2_c = '0;
        end else if (wbShouldWrite && (wbWriteIndex == inSource2Index)) begin
            cap_src2_c = wbWriteData;
        end
    end

    // Next-state selection: flush > stall (with refresh) > hazard bubble > capture.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        src1_idx_d  = src1_idx_q;
        src2_idx_d  = src2_idx_q;
        src1_data_d = src1_data_q;
        src2_data_d = src2_data_q;
        imm_d       = imm_q;
        rd_idx_d    = rd_idx_q;
        control_d   = control_q;

        if (flush || (!stall && load_use_c)) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            src1_idx_d  = '0;
            src2_idx_d  = '0;
            src1_data_d = '0;
            src2_data_d = '0;
            imm_d       = '0;
            rd_idx_d    = '0;
            control_d   = '0;
        end else if (stall) begin
            if (wb_nonzero_c && (wbWriteIndex == src1_idx_q)) begin
                src1_data_d = wbWriteData;
            end
            if (wb_nonzero_c && (wbWriteIndex == src2_idx_q)) begin
                src2_data_d = wbWriteData;
            end
        end else begin
            valid_d     = inValid;
            pc_d        = inPc;
            src1_idx_d  = inSource1Index;
            src2_idx_d  = inSource2Index;
            src1_data_d = cap_src1_c;
            src2_data_d = cap_src2_c;
            imm_d       = inImmediate;
            rd_idx_d    = inRdIndex;
            control_d   = inControl;
        end
    end

    // Stage register; reset loads a bubble.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            src1_idx_q  <= '0;
            src2_idx_q  <= '0;
            src1_data_q <= '0;
            src2_data_q <= '0;
            imm_q       <= '0;
            rd_idx_q    <= '0;
            control_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            src1_idx_q  <= src1_idx_d;
            src2_idx_q  <= src2_idx_d;
            src1_data_q <= src1_data_d;
            src2_data_q <= src2_data_d;
            imm_q       <= imm_d;
            rd_idx_q    <= rd_idx_d;
            control_q   <= control_d;
        end
    end

    assign loadUseHazard   = load_use_c;
    assign outValid        = valid_q;
    assign outPc           = pc_q;
    assign outSource1Index = src1_idx_q;
    assign outSource2Index = src2_idx_q;
    assign outSource1Data  = src1_data_q;
    assign outSource2Data  = src2_data_q;
    assign outImmediate    = imm_q;
    assign outRdIndex      = rd_idx_q;
    assign outControl      = control_q;

endmodule

// File: tb/tb_decode_execute_register.sv
// Testbench for decode_execute_register: directed steps, expected stage
// contents queued when stimulus is applied and compared after the edge.
module tb_decode_execute_register;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  s1i;
        logic [4:0]  s2i;
        logic [31:0] s1d;
        logic [31:0] s2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } stage_t;

    logic        clk;
    logic        resetN;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic [31:0] inPc;
    logic [4:0]  inSource1Index;
    logic [4:0]  inSource2Index;
    logic [31:0] inSource1Data;
    logic [31:0] inSource2Data;
    logic [31:0] inImmediate;
    logic [4:0]  inRdIndex;
    logic [15:0] inControl;
    logic        wbShouldWrite;
    logic [4:0]  wbWriteIndex;
    logic [31:0] wbWriteData;
    logic        loadUseHazard;
    logic        outValid;
    logic [31:0] outPc;
    logic [4:0]  outSource1Index;
    logic [4:0]  outSource2Index;
    logic [31:0] outSource1Data;
    logic [31:0] outSource2Data;
    logic [31:0] outImmediate;
    logic [4:0]  outRdIndex;
    logic [15:0] outControl;

    int     n_cmp = 0;
    int     n_err = 0;
    stage_t exp_q[$];
    stage_t bubble;

    decode_execute_register #(
        .DATA_WIDTH(32), .INDEX_WIDTH(5), .CONTROL_WIDTH(16), .LOAD_BIT(0)
    ) dut (
        .clk(clk), .resetN(resetN), .stall(stall), .flush(flush),
        .inValid(inValid), .inPc(inPc),
        .inSource1Index(inSource1Index), .inSource2Index(inSource2Index),
        .inSource1Data(inSource1Data), .inSource2Data(inSource2Data),
        .inImmediate(inImmediate), .inRdIndex(inRdIndex), .inControl(inControl),
        .wbShouldWrite(wbShouldWrite), .wbWriteIndex(wbWriteIndex),
        .wbWriteData(wbWriteData), .loadUseHazard(loadUseHazard),
        .outValid(outValid), .outPc(outPc),
        .outSource1Index(outSource1Index), .outSource2Index(outSource2Index),
        .outSource1Data(outSource1Data), .outSource2Data(outSource2Data),
        .outImmediate(outImmediate), .outRdIndex(outRdIndex), .outControl(outControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_stage(input string tag, input stage_t e);
        check({tag, ".valid"}, 64'(outValid),        64'(e.valid));
        check({tag, ".pc"},    64'(outPc),           64'(e.pc));
        check({tag, ".s1i"},   64'(outSource1Index), 64'(e.s1i));
        check({tag, ".s2i"},   64'(outSource2Index), 64'(e.s2i));
        check({tag, ".s1d"},   64'(outSource1Data),  64'(e.s1d));
        check({tag, ".s2d"},   64'(outSource2Data),  64'(e.s2d));
        check({tag, ".imm"},   64'(outImmediate),    64'(e.imm));
        check({tag, ".rd"},    64'(outRdIndex),      64'(e.rd));
        check({tag, ".ctrl"},  64'(outControl),      64'(e.ctrl));
    endtask

    // Apply decode inputs (called just after a negedge).
    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [4:0] s1i, input logic [31:0] s1d,
                         input logic [4:0] s2i, input logic [31:0] s2d,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic [15:0] ctrl);
        inValid        = v;
        inPc           = pc;
        inSource1Index = s1i;
        inSource1Data  = s1d;
        inSource2Index = s2i;
        inSource2Data  = s2d;
        inImmediate    = imm;
        inRdIndex      = rd;
        inControl      = ctrl;
    endtask

    task automatic wb(input logic we, input logic [4:0] idx, input logic [31:0] data);
        wbShouldWrite = we;
        wbWriteIndex  = idx;
        wbWriteData   = data;
    endtask

    task automatic push(input logic v, input logic [31:0] pc,
                        input logic [4:0] s1i, input logic [31:0] s1d,
                        input logic [4:0] s2i, input logic [31:0] s2d,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [15:0] ctrl);
        stage_t e;
        e = '{valid: v, pc: pc, s1i: s1i, s2i: s2i, s1d: s1d, s2d: s2d,
              imm: imm, rd: rd, ctrl: ctrl};
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare DUT against the oldest queued expectation.
    task automatic step(input string tag);
        stage_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 64'(1), 64'(0));
        end else begin
            e = exp_q.pop_front();
            compare_stage(tag, e);
        end
    endtask

    initial begin
        bubble = '0;
        resetN = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b1, 32'h40, 5'd1, 32'h11, 5'd2, 32'h22, 32'h33, 5'd3, 16'h0001);
        wb(1'b0, 5'd0, 32'h0);
        #3;
        compare_stage("reset", bubble);
        check("reset.hazard", 64'(loadUseHazard), 64'(0));
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 16'h0);

        // Plain capture.
        @(negedge clk);
        drive(1'b1, 32'h100, 5'd3, 32'hA, 5'd2, 32'hB, 32'h44, 5'd5, 16'h0010);
        push(1'b1, 32'h100, 5'd3, 32'hA, 5'd2, 32'hB, 32'h44, 5'd5, 16'h0010);
        step("capture");

        // Same-cycle writeback bypass on rs1, rs2 = x0 reads zero.
        @(negedge clk);
        drive(1'b1, 32'h104, 5'd7, 32'h1, 5'd0, 32'h99, 32'h8, 5'd6, 16'h0020);
        wb(1'b1, 5'd7, 32'h55);
        #1;
        check("nonload.hazard", 64'(loadUseHazard), 64'(0));
        push(1'b1, 32'h104, 5'd7, 32'h55, 5'd0, 32'h0, 32'h8, 5'd6, 16'h0020);
        step("bypass");

        // Writeback disabled: matching index ignored.
        @(negedge clk);
        drive(1'b1, 32'h108, 5'd8, 32'h123, 5'd9, 32'h456, 32'h0, 5'd1, 16'h0040);
        wb(1'b0, 5'd8, 32'hDEAD);
        push(1'b1, 32'h108, 5'd8, 32'h123, 5'd9, 32'h456, 32'h0, 5'd1, 16'h0040);
        step("wb_off");

        // Stall with refresh of held sources.
        @(negedge clk);
        drive(1'b1, 32'h10C, 5'd10, 32'h22, 5'd9, 32'h11, 32'h5, 5'd12, 16'h0002);
        wb(1'b0, 5'd0, 32'h0);
        push(1'b1, 32'h10C, 5'd10, 32'h22, 5'd9, 32'h11, 32'h5, 5'd12, 16'h0002);
        step("pre_stall");
        @(negedge clk);
        stall = 1'b1;
        drive(1'b1, 32'hDEAD, 5'd1, 32'h1, 5'd1, 32'h1, 32'h1, 5'd1, 16'hFFFF);
        wb(1'b1, 5'd9, 32'hBEEF);
        push(1'b1, 32'h10C, 5'd10, 32'h22, 5'd9, 32'hBEEF, 32'h5, 5'd12, 16'h0002);
        step("stall_refresh2");
        @(negedge clk);
        wb(1'b1, 5'd10, 32'h77);
        push(1'b1, 32'h10C, 5'd10, 32'h77, 5'd9, 32'hBEEF, 32'h5, 5'd12, 16'h0002);
        step("stall_refresh1");
        @(negedge clk);
        wb(1'b1, 5'd0, 32'h1234);
        push(1'b1, 32'h10C, 5'd10, 32'h77, 5'd9, 32'hBEEF, 32'h5, 5'd12, 16'h0002);
        step("stall_wb_x0");

        // Load followed by dependent instruction.
        @(negedge clk);
        stall = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        drive(1'b1, 32'h200, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd4, 16'h0001);
        push(1'b1, 32'h200, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 5'd4, 16'h0001);
        step("load");
        @(negedge clk);
        drive(1'b0, 32'h204, 5'd3, 32'h33, 5'd4, 32'h44, 32'h9, 5'd7, 16'h0000);
        #1;
        check("hazard.invalid", 64'(loadUseHazard), 64'(0));
        inValid = 1'b1;
        #1;
        check("hazard.raised", 64'(loadUseHazard), 64'(1));
        exp_q.push_back(bubble);
        step("hazard_bubble");
        @(negedge clk);
        #1;
        check("hazard.after_bubble", 64'(loadUseHazard), 64'(0));
        push(1'b1, 32'h204, 5'd3, 32'h33, 5'd4, 32'h44, 32'h9, 5'd7, 16'h0000);
        step("hazard_recapture");

        // Flush wins over stall.
        @(negedge clk);
        flush = 1'b1;
        stall = 1'b1;
        exp_q.push_back(bubble);
        step("flush_stall");
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;

        // Asynchronous reset mid-cycle while stalled.
        drive(1'b1, 32'h300, 5'd5, 32'h55, 5'd6, 32'h66, 32'h7, 5'd8, 16'h0001);
        push(1'b1, 32'h300, 5'd5, 32'h55, 5'd6, 32'h66, 32'h7, 5'd8, 16'h0001);
        step("pre_reset");
        @(negedge clk);
        stall = 1'b1;
        drive(1'b1, 32'h304, 5'd8, 32'h1, 5'd2, 32'h2, 32'h0, 5'd9, 16'h0);
        #1;
        check("pre_reset.hazard", 64'(loadUseHazard), 64'(1));
        #1;
        resetN = 1'b0;
        #1;
        compare_stage("async_reset", bubble);
        check("async_reset.hazard", 64'(loadUseHazard), 64'(0));
        @(negedge clk);
        resetN = 1'b1;
        stall  = 1'b0;

        // Capture still works after reset.
        @(negedge clk);
        drive(1'b1, 32'h400, 5'd11, 32'hC0FFEE, 5'd12, 32'h12, 32'hF, 5'd13, 16'h0100);
        wb(1'b1, 5'd12, 32'hABCD);
        push(1'b1, 32'h400, 5'd11, 32'hC0FFEE, 5'd12, 32'hABCD, 32'hF, 5'd13, 16'h0100);
        step("post_reset");

        check("queue_drain", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
